// File: rtl/instr_cycle_sequencer.sv
// Fetches opcodes into ir and steps the decoder's cycle count 0..last(ir) on phase-2 edges.
// Latency: one FETCH clock at minimum, then last(ir)+1 step edges; all outputs except fetch_req are registered.
// Backpressure: fetch_req holds until fetch_ack; stall freezes execution while clk_ph2 keeps toggling.
//
// Ports:
//   sys_clock, rst       clock and synchronous active-high reset
//   run, stall           level controls: keep sequencing / freeze execution
//   fetch_req/ack/data   opcode handshake; a transfer happens when req && ack
//   clk_ph2              phase-2 enable for the decoder, toggles every clock
//   cycle, ir            current execution cycle (all-ones when idle) and opcode
//   instr_done           one-clock pulse per retired instruction
//   halted, illegal      sticky status flags
//
// Build option: define ILLEGAL_TRAP_EN to make unknown opcodes trap into HALT
// (sets illegal and halted, no instr_done). Without it they retire as a NOP.

module instr_cycle_sequencer #(
   parameter int unsigned     IR_W    = 8,
   parameter int unsigned     CYC_W   = 3,
   parameter logic [IR_W-1:0] HALT_OP = 8'hFF
) (
   input  logic             sys_clock,
   input  logic             rst,
   input  logic             run,
   input  logic             stall,
   output logic             fetch_req,
   input  logic             fetch_ack,
   input  logic [IR_W-1:0]  fetch_data,
   output logic             clk_ph2,
   output logic [CYC_W-1:0] cycle,
   output logic [IR_W-1:0]  ir,
   output logic             instr_done,
   output logic             halted,
   output logic             illegal
);

   localparam logic [CYC_W-1:0] CYC_IDLE = '1;
   localparam logic [IR_W-1:0]  OP_NOP   = IR_W'(8'h00);
   localparam logic [IR_W-1:0]  OP_X01   = IR_W'(8'h01);
   localparam logic [IR_W-1:0]  OP_X02   = IR_W'(8'h02);
   localparam logic [IR_W-1:0]  OP_X03   = IR_W'(8'h03);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t           state, state_nxt;
   logic [IR_W-1:0]  ir_nxt;
   logic [CYC_W-1:0] cycle_nxt;
   logic             done_nxt;
   logic             halted_nxt;
   logic             step;

   // Last execution cycle per opcode; unknown opcodes get a single cycle.
   function automatic logic [CYC_W-1:0] last_cycle(input logic [IR_W-1:0] op);
      if (op == OP_X01 || op == OP_X02)
         return CYC_W'(1);
      return '0;
   endfunction

   // Execution only advances on phase-2 edges, so every cycle value is seen
   // by exactly one decoder ph2 edge.
   assign step = clk_ph2 & ~stall;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_nxt;

   function automatic logic is_legal(input logic [IR_W-1:0] op);
      return (op == OP_NOP) || (op == OP_X01) || (op == OP_X02) ||
             (op == OP_X03) || (op == HALT_OP);
   endfunction

   always_ff @(posedge sys_clock) begin
      if (rst)
         illegal_q <= 1'b0;
      else
         illegal_q <= illegal_nxt;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      ir_nxt     = ir;
      cycle_nxt  = cycle;
      done_nxt   = 1'b0;
      halted_nxt = halted;
      fetch_req  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_nxt = illegal_q;
`endif
      case (state)
         S_IDLE: begin
            cycle_nxt = CYC_IDLE;
            if (run)
               state_nxt = S_FETCH;
         end
         S_FETCH: begin
            fetch_req = 1'b1;
            // A completed handshake is never dropped, even if run falls in
            // the same clock; the opcode is already on the bus.
            if (fetch_ack) begin
               ir_nxt    = fetch_data;
               cycle_nxt = '0;
               state_nxt = S_EXEC;
            end else if (!run) begin
               state_nxt = S_IDLE;
            end
         end
         S_EXEC: begin
            if (step) begin
               if (cycle < last_cycle(ir)) begin
                  cycle_nxt = cycle + CYC_W'(1);
               end else begin
                  cycle_nxt = CYC_IDLE;
`ifdef ILLEGAL_TRAP_EN
                  if (!is_legal(ir)) begin
                     illegal_nxt = 1'b1;
                     halted_nxt  = 1'b1;
                     state_nxt   = S_HALT;
                  end else
`endif
                  begin
                     done_nxt = 1'b1;
                     if (ir == HALT_OP) begin
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                     end else if (run) begin
                        state_nxt = S_FETCH;
                     end else begin
                        state_nxt = S_IDLE;
                     end
                  end
               end
            end
         end
         S_HALT: begin
            cycle_nxt  = CYC_IDLE;
            halted_nxt = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (rst) begin
         state      <= S_IDLE;
         ir         <= '0;
         cycle      <= CYC_IDLE;
         clk_ph2    <= 1'b0;
         instr_done <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         ir         <= ir_nxt;
         cycle      <= cycle_nxt;
         clk_ph2    <= ~clk_ph2;
         instr_done <= done_nxt;
         halted     <= halted_nxt;
      end
   end

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
module tb_instr_cycle_sequencer;

   logic       sys_clock;
   logic       rst;
   logic       run;
   logic       stall;
   logic       fetch_req;
   logic       fetch_ack;
   logic [7:0] fetch_data;
   logic       clk_ph2;
   logic [2:0] cycle;
   logic [7:0] ir;
   logic       instr_done;
   logic       halted;
   logic       illegal;

   instr_cycle_sequencer dut (
      .sys_clock  (sys_clock),
      .rst        (rst),
      .run        (run),
      .stall      (stall),
      .fetch_req  (fetch_req),
      .fetch_ack  (fetch_ack),
      .fetch_data (fetch_data),
      .clk_ph2    (clk_ph2),
      .cycle      (cycle),
      .ir         (ir),
      .instr_done (instr_done),
      .halted     (halted),
      .illegal    (illegal)
   );

   initial begin
      sys_clock = 1'b0;
      forever #5 sys_clock = ~sys_clock;
   end

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   // Retirement kinds expected for a fetched opcode.
   localparam int K_DONE = 0;
   localparam int K_HALT = 1;
   localparam int K_TRAP = 2;

   typedef struct {
      logic [7:0] op;
      int         kind;
   } rec_t;

   rec_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_pop = 0;

   // ---------------- reference model (spec-level) ----------------
   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_EXEC  = 2;
   localparam int M_HALT  = 3;

   bit         m_live = 1'b0;
   bit         m_ph2;
   int         m_mode;
   logic [7:0] m_op;
   int         m_steps;    // step edges consumed by the current instruction, -1 when none
   bit         m_done;
   bit         m_halted;
   bit         m_illegal;

   function automatic int op_cycles(input logic [7:0] op);
      if (op == 8'h01 || op == 8'h02) return 2;
      return 1;
   endfunction

   function automatic bit op_legal(input logic [7:0] op);
      return op == 8'h00 || op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'hFF;
   endfunction

   function automatic int op_kind(input logic [7:0] op);
      if (TRAP && !op_legal(op)) return K_TRAP;
      if (op == 8'hFF) return K_HALT;
      return K_DONE;
   endfunction

   always @(posedge sys_clock) begin
      if (rst) begin
         m_live    = 1'b1;
         m_ph2     = 1'b0;
         m_mode    = M_IDLE;
         m_op      = 8'h00;
         m_steps   = -1;
         m_done    = 1'b0;
         m_halted  = 1'b0;
         m_illegal = 1'b0;
         sb_q.delete();
      end else if (m_live) begin
         m_done = 1'b0;
         case (m_mode)
            M_IDLE: if (run) m_mode = M_FETCH;
            M_FETCH: begin
               if (fetch_ack) begin
                  m_op    = fetch_data;
                  m_steps = 0;
                  m_mode  = M_EXEC;
                  sb_q.push_back('{op: fetch_data, kind: op_kind(fetch_data)});
               end else if (!run) begin
                  m_mode = M_IDLE;
               end
            end
            M_EXEC: begin
               if (m_ph2 && !stall) begin
                  if (m_steps + 1 < op_cycles(m_op)) begin
                     m_steps = m_steps + 1;
                  end else begin
                     m_steps = -1;
                     case (op_kind(m_op))
                        K_TRAP: begin
                           m_illegal = 1'b1;
                           m_halted  = 1'b1;
                           m_mode    = M_HALT;
                        end
                        K_HALT: begin
                           m_done   = 1'b1;
                           m_halted = 1'b1;
                           m_mode   = M_HALT;
                        end
                        default: begin
                           m_done = 1'b1;
                           m_mode = run ? M_FETCH : M_IDLE;
                        end
                     endcase
                  end
               end
            end
            default: ;
         endcase
         m_ph2 = !m_ph2;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   logic prev_illegal = 1'b0;

   always @(negedge sys_clock) begin
      if (m_live) begin
         check("clk_ph2",    32'(clk_ph2),    32'(m_ph2));
         check("cycle",      32'(cycle),      (m_steps < 0) ? 32'd7 : 32'(m_steps));
         check("fetch_req",  32'(fetch_req),  32'(m_mode == M_FETCH));
         check("ir",         32'(ir),         32'(m_op));
         check("instr_done", 32'(instr_done), 32'(m_done));
         check("halted",     32'(halted),     32'(m_halted));
         check("illegal",    32'(illegal),    32'(m_illegal));

         if (instr_done === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_done_unexpected @%0t: got instr_done with no outstanding opcode, expected none", $time);
            end else begin
               rec_t r;
               r = sb_q.pop_front();
               n_pop++;
               check("sb_done_op",   32'(ir),            32'(r.op));
               check("sb_done_kind", 32'(r.kind != K_TRAP), 32'd1);
               check("sb_done_halt", 32'(halted),        32'(r.kind == K_HALT));
            end
         end
         if (illegal === 1'b1 && prev_illegal !== 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_trap_unexpected @%0t: got illegal rise with no outstanding opcode, expected none", $time);
            end else begin
               rec_t r;
               r = sb_q.pop_front();
               n_pop++;
               check("sb_trap_kind", 32'(r.kind), 32'(K_TRAP));
            end
         end
         prev_illegal = illegal;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge sys_clock);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      tick(n);
      rst = 1'b0;
   endtask

   task automatic feed(input logic [7:0] op, input logic hold);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (fetch_req === 1'b1) got = 1'b1;
         else tick(1);
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL feed_wait @%0t: got no fetch_req within 40 clocks, expected a request", $time);
      end
      fetch_data = op;
      fetch_ack  = 1'b1;
      tick(1);
      fetch_ack  = hold;
   endtask

   function automatic logic [7:0] pick_op();
      int r;
      logic [7:0] v;
      r = $urandom_range(0, 19);
      v = 8'($urandom_range(0, 255));
      if (r < 16) return 8'(r % 4);
      if (r < 18) return v;
      if (r == 18) return 8'hFF;
      return 8'h7E;
   endfunction

   initial begin
      rst = 1'b1; run = 1'b0; stall = 1'b0; fetch_ack = 1'b0; fetch_data = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(4);

      // single two-cycle opcode
      run = 1'b1;
      feed(8'h01, 1'b0);
      tick(6);

      // stream with ack held high
      feed(8'h02, 1'b1);
      feed(8'h03, 1'b1);
      feed(8'h00, 1'b1);
      fetch_ack = 1'b0;
      tick(6);

      // stall during cycle 0 of opcode 01
      feed(8'h01, 1'b0);
      stall = 1'b1;
      tick(6);
      stall = 1'b0;
      tick(6);

      // halt opcode with run held high
      feed(8'hFF, 1'b0);
      tick(10);
      do_reset(2);

      // unknown opcode
      run = 1'b1;
      feed(8'h7E, 1'b0);
      tick(8);
      do_reset(2);

      // reset in cycle 1 of opcode 02
      run = 1'b1;
      feed(8'h02, 1'b0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            if (cycle === 3'd1) seen = 1'b1;
            else tick(1);
         end
         if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL midop_wait @%0t: got no cycle 1 within 10 clocks, expected cycle 1", $time);
         end
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(4);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0);
         run        = $urandom_range(0, 9) != 0;
         stall      = $urandom_range(0, 3) == 0;
         fetch_ack  = 1'($urandom_range(0, 1));
         fetch_data = pick_op();
         tick(1);
      end

      // drain
      rst = 1'b0; run = 1'b0; stall = 1'b0; fetch_ack = 1'b0;
      tick(12);
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      check("sb_activity", 32'(n_pop >= 20), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
